// File: rtl/wb_dmi_host.sv
// Wishbone-pipelined slave that issues one RISC-V DMI request per CMD write and captures its response.
// Latency: wbs_ack one cycle after cyc&stb; a DMI transaction completes no sooner than 2 cycles after the CMD ack.
// Backpressure: wbs_stall is never raised; DMI request holds until dmi_req_ready, optional timeout bounds the wait for dmi_resp_valid.
module wb_dmi_host #(
    // Only a 32-bit Wishbone data path is supported.
    parameter int BusWidth      = 32,
    // RESP cycles before a hung transaction is aborted; 0 waits forever.
    parameter int TimeoutCycles = 1024
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                wbs_cyc,
    input  logic                wbs_stb,
    input  logic                wbs_we,
    input  logic [3:0]          wbs_adr,
    input  logic [3:0]          wbs_sel,
    input  logic [BusWidth-1:0] wbs_dat_i,
    output logic [BusWidth-1:0] wbs_dat_o,
    output logic                wbs_ack,
    output logic                wbs_stall,
    output logic                wbs_err,

    output logic                dmi_rst_n,
    output logic                dmi_req_valid,
    input  logic                dmi_req_ready,
    output logic [40:0]         dmi_req,
    input  logic                dmi_resp_valid,
    output logic                dmi_resp_ready,
    input  logic [33:0]         dmi_resp
);

    // The counter only ever holds 0 .. TimeoutCycles-1 before the abort fires.
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegAddr   = 2'd1;
    localparam logic [1:0] RegCmd    = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]     req_data_q;
    logic [31:0]     resp_data_q;
    logic [6:0]      addr_q;
    logic [40:0]     held_req_q;
    logic [1:0]      last_resp_q;
    logic            done_q;
    logic            busyerr_q;
    logic            timeout_q;
    logic [CntW-1:0] cnt_q;
    logic            rst_req_q;
    logic            rst_pulse_q;

    logic            accept;
    logic            wr;
    logic [1:0]      reg_sel;
    logic            wr_data;
    logic            wr_addr;
    logic            wr_cmd;
    logic            wr_status;
    logic            cmd_reset;
    logic            cmd_op;
    logic            start;
    logic            busy_collision;
    logic            req_fire;
    logic            resp_fire;
    logic            timeout_hit;
    logic            resp_done;
    logic            to_done;
    logic            complete;
    logic            clr_done;
    logic            busy;
    logic [BusWidth-1:0] rdata;

    // Byte-lane bits of the address carry no register information.
    logic unused_adr;
    assign unused_adr = ^wbs_adr[1:0];

    // Bus decode: partial-select writes are acked but otherwise have no effect.
    assign accept    = wbs_cyc & wbs_stb;
    assign reg_sel   = wbs_adr[3:2];
    assign wr        = accept & wbs_we & (wbs_sel == 4'hF);
    assign wr_data   = wr & (reg_sel == RegData);
    assign wr_addr   = wr & (reg_sel == RegAddr);
    assign wr_cmd    = wr & (reg_sel == RegCmd);
    assign wr_status = wr & (reg_sel == RegStatus);

    // dmireset dominates any op carried in the same CMD write.
    assign cmd_reset      = wr_cmd & wbs_dat_i[2];
    assign cmd_op         = wr_cmd & ~wbs_dat_i[2] &
                            ((wbs_dat_i[1:0] == 2'd1) | (wbs_dat_i[1:0] == 2'd2));
    assign start          = cmd_op & (state_q == ST_IDLE);
    assign busy_collision = cmd_op & (state_q != ST_IDLE);

    assign req_fire    = (state_q == ST_REQ) & dmi_req_ready;
    assign resp_fire   = (state_q == ST_RESP) & dmi_resp_valid;
    assign timeout_hit = (TimeoutCycles != 0) & (state_q == ST_RESP) & ~dmi_resp_valid &
                         (cnt_q == CntLast);

    // An abort by dmireset discards whatever completion would have happened that cycle.
    assign resp_done = resp_fire & ~cmd_reset;
    assign to_done   = timeout_hit & ~cmd_reset;
    assign complete  = resp_done | to_done;
    assign clr_done  = (wr & (reg_sel != RegStatus)) | (wr_status & wbs_dat_i[1]);
    assign busy      = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: dmireset returns to IDLE from anywhere; otherwise request, response, optional timeout.
    always_comb begin
        state_d = state_q;
        if (cmd_reset) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) state_d = ST_REQ;
                ST_REQ:  if (req_fire) state_d = ST_RESP;
                ST_RESP: if (resp_fire || timeout_hit) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read mux; CMD is write-only and reads as zero.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            RegData:   rdata = BusWidth'(resp_data_q);
            RegAddr:   rdata = BusWidth'(addr_q);
            RegCmd:    rdata = '0;
            RegStatus: rdata = BusWidth'({timeout_q, busyerr_q, last_resp_q, done_q, busy});
            default:   rdata = '0;
        endcase
    end

    // Wishbone response: single-cycle ack for every accepted strobe, data only on reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack   <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack   <= accept;
            wbs_dat_o <= (accept && !wbs_we) ? rdata : '0;
        end
    end

    // Software-visible DATA/ADDR registers and the request snapshot taken at launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_data_q <= '0;
            addr_q     <= '0;
            held_req_q <= '0;
        end else begin
            if (wr_data) req_data_q <= wbs_dat_i[31:0];
            if (wr_addr) addr_q <= wbs_dat_i[6:0];
            if (start) held_req_q <= {addr_q, wbs_dat_i[1:0], req_data_q};
        end
    end

    // Response capture; a timeout reports "failed" but leaves the read data alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
            last_resp_q <= '0;
        end else begin
            if (resp_done) begin
                resp_data_q <= dmi_resp[33:2];
                last_resp_q <= dmi_resp[1:0];
            end else if (to_done) begin
                last_resp_q <= 2'd2;
            end
        end
    end

    // Sticky status bits; a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            busyerr_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (complete) done_q <= 1'b1;
            else if (clr_done) done_q <= 1'b0;

            if (busy_collision) busyerr_q <= 1'b1;
            else if (wr_status && wbs_dat_i[4]) busyerr_q <= 1'b0;

            if (to_done) timeout_q <= 1'b1;
            else if (wr_status && wbs_dat_i[5]) timeout_q <= 1'b0;
        end
    end

    // Timeout counter runs only while waiting in RESP, zero otherwise so each entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_RESP) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Two-stage delay puts the one-cycle DM reset pulse in the cycle after the CMD ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_req_q   <= 1'b0;
            rst_pulse_q <= 1'b0;
        end else begin
            rst_req_q   <= cmd_reset;
            rst_pulse_q <= rst_req_q;
        end
    end

    assign wbs_stall = 1'b0;
    assign wbs_err   = 1'b0;

    // Handshake outputs are forced inactive while rst is held, independent of the state register.
    assign dmi_req        = held_req_q;
    assign dmi_req_valid  = ~rst & (state_q == ST_REQ);
    assign dmi_resp_ready = ~rst & (state_q != ST_REQ);
    assign dmi_rst_n      = ~(rst | rst_pulse_q);

endmodule
